output_buffer_mmio: RTL and testbench
=====================================

Name: output_buffer_mmio

Overview:
Parametrised successor of the memory-mapped output buffer in the LSU. It decodes a 256-byte window at BASE_ADDR and drives the red LEDs, green LEDs, N_HEX seven-segment digits and the LCD, with byte-lane writes, readback of every register, and atomic set/clear/toggle aliases for the LED registers. LCD writes go through a small FIFO that drains over a valid/ready handshake, so the CPU never stalls on a slow LCD.

Parameters:
BASE_ADDR, 16'h7000, window base; a register hits when i_addr[15:8]==BASE_ADDR[15:8].
LED_W, 32, width of the LEDR and LEDG registers (1..32).
N_HEX, 8, number of 7-segment digits (multiple of 4, 4..16).
LCD_DEPTH, 4, LCD FIFO entries (power of 2, >=2).
BLINK_DIV, 24, blink counter width (used only with the optional feature).

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous reset, active-low
i_addr  in  16  byte address
i_wr_data  in  32  store data
i_wr_en  in  4  byte-lane write enables; a write occurs when any bit is set and the address hits
o_ld_data  out  32  combinational readback
o_io_ledr  out  LED_W  red LEDs
o_io_ledg  out  LED_W  green LEDs
o_io_hex  out  7*N_HEX  digit k at [7k+6:7k]
o_io_lcd  out  32  FIFO head word
o_lcd_valid  out  1  FIFO not empty
i_lcd_ready  in  1  LCD accepts the head word

Behaviour:
- Reset (i_rst_n=0, asynchronous): LEDR, LEDG, all HEX and status registers = 0. FIFO empty (rd_ptr = wr_ptr = count = 0), so o_lcd_valid=0 and o_io_lcd=0. It is legal to assert reset mid-handshake; any pending FIFO data is discarded.
- Address offsets use a = i_addr[7:0] with bits [1:0] ignored.
- LEDR aliases: 0x00 WRITE, 0x04 SET (r|=d), 0x08 CLR (r&=~d), 0x0C TOG (r^=d).
- LEDG aliases: the same four, at 0x10/0x14/0x18/0x1C.
- Byte lanes: each alias operation applies only to bytes whose i_wr_en bit is set. Bits at or above LED_W are dropped.
- HEX: 0x20+4w addresses digit word w, for w < N_HEX/4. Lane k writes digit 4w+k from i_wr_data[8k+6:8k].
- 0x30 LCD: a write with any i_wr_en bit set pushes the full 32-bit word.
- 0x34 STATUS: read returns {overflow[8], full[7], count[6:0]}. Any write to 0x34 clears overflow.
- Unmapped offsets: writes are ignored and reads return 0.
- Writes take effect at the rising edge; outputs are registered (1-cycle latency from the write cycle).
- Readback: any LED alias returns the current register, zero-extended. 0x30 returns the FIFO head (0 when empty). Reads have no side effects.
- FIFO pop occurs when o_lcd_valid && i_lcd_ready.
- FIFO push is accepted when count<LCD_DEPTH, or when full with a pop in the same cycle. A simultaneous push and pop leaves count unchanged.
- A push while full with no pop is dropped, the contents are unchanged, and overflow is set (sticky).
- Pointers wrap modulo LCD_DEPTH.
- o_io_lcd is the head entry; it is stable while o_lcd_valid=1 and i_lcd_ready=0.
- If i_lcd_ready=1 while empty, nothing happens.

Optional Feature:
OUTPUT_BUFFER_BLINK_EN.
- Defined:
  - Register BLINK_MASK (LED_W bits) at offset 0x38; it takes byte-lane writes, reads back, and resets to 0.
  - A free-running BLINK_DIV-bit counter resets to 0.
  - o_io_ledr = ledr & ~(BLINK_MASK & {LED_W{cnt[BLINK_DIV-1]}}).
- Undefined:
  - No counter.
  - 0x38 is unmapped (reads 0, writes ignored).
  - o_io_ledr = ledr.

Test Plan:
- Reset then write 0x7000 = 32'hA5A5_0F0F with wr_en=4'hF; write 0x7004 = 32'h0000_00F0 (SET) -> o_io_ledr = 32'hA5A5_0FFF. Write 0x7008 = 32'h0000_000F (CLR) -> 32'hA5A5_0FF0. Write 0x700C = 32'hFFFF_0000 (TOG) -> 32'h5A5A_0FF0. Read 0x7004 -> 32'h5A5A_0FF0.
- Write 0x7024 = 32'h7F06_5B4F with wr_en=4'b0101 -> digit4 = 7'h4F, digit6 = 7'h06; digits 5 and 7 unchanged (0).
- Hold i_lcd_ready=0 and push 5 words 1..5 to 0x7030 (LCD_DEPTH=4) -> status reads 0x184; head = 1. Set i_lcd_ready=1 -> 1, 2, 3, 4 are presented on consecutive cycles, then o_lcd_valid=0. Write 0x7034 -> status reads 0x000.
- Full FIFO with i_lcd_ready=1 and a push of 9 in the same cycle -> count stays 4; the push is accepted and overflow is not set.
- Pulse i_rst_n low asynchronously (no clock edge) mid-drain with LEDG=32'h1234 -> all outputs 0 immediately; o_lcd_valid=0.
- With OUTPUT_BUFFER_BLINK_EN and BLINK_DIV=4: LEDR = 32'hFF, mask 0x7038 = 32'h0F -> o_io_ledr alternates 32'hFF / 32'hF0, switching every 8 cycles.

Source files
------------

// File: rtl/output_buffer_mmio_if.sv
// rtl/output_buffer_mmio_if.sv - CPU-side load/store bus for the memory-mapped output buffer
interface output_buffer_mmio_if;
    logic [15:0] i_addr;
    logic [31:0] i_wr_data;
    logic [3:0]  i_wr_en;
    logic [31:0] o_ld_data;

    modport master (
        output i_addr,
        output i_wr_data,
        output i_wr_en,
        input  o_ld_data
    );

    modport slave (
        input  i_addr,
        input  i_wr_data,
        input  i_wr_en,
        output o_ld_data
    );
endinterface

// File: rtl/output_buffer_mmio.sv
// rtl/output_buffer_mmio.sv - memory-mapped LED/HEX/LCD output buffer; optional blink feature under OUTPUT_BUFFER_BLINK_EN
module output_buffer_mmio #(
    parameter logic [15:0] BASE_ADDR = 16'h7000,
    parameter int          LED_W     = 32,
    parameter int          N_HEX     = 8,
    parameter int          LCD_DEPTH = 4,
    parameter int          BLINK_DIV = 24
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    output_buffer_mmio_if.slave  bus,
    output logic [LED_W-1:0]     o_io_ledr,
    output logic [LED_W-1:0]     o_io_ledg,
    output logic [7*N_HEX-1:0]   o_io_hex,
    output logic [31:0]          o_io_lcd,
    output logic                 o_lcd_valid,
    input  logic                 i_lcd_ready
);

    localparam int PW        = (LCD_DEPTH > 1) ? $clog2(LCD_DEPTH) : 1;
    localparam int CW        = PW + 1;
    localparam int HEX_WORDS = N_HEX / 4;

    // Word indices within the 256-byte window (byte offset / 4)
    localparam logic [5:0] W_LCD    = 6'd12;
    localparam logic [5:0] W_STATUS = 6'd13;
    localparam logic [5:0] W_BLINK  = 6'd14;

    // Alias operations selected by offset bits [3:2] of the LED block
    localparam logic [1:0] OP_WRITE = 2'd0;
    localparam logic [1:0] OP_SET   = 2'd1;
    localparam logic [1:0] OP_CLR   = 2'd2;

    // Address decode
    logic        hit;
    logic        wr;
    logic [5:0]  word;
    logic [31:0] lane_mask;
    logic [31:0] wdata;
    logic        unused_addr_bits;

    assign hit       = (bus.i_addr[15:8] == BASE_ADDR[15:8]);
    assign word      = bus.i_addr[7:2];
    assign wr        = hit && (|bus.i_wr_en);
    assign wdata     = bus.i_wr_data;
    assign lane_mask = {{8{bus.i_wr_en[3]}}, {8{bus.i_wr_en[2]}},
                        {8{bus.i_wr_en[1]}}, {8{bus.i_wr_en[0]}}};
    assign unused_addr_bits = ^bus.i_addr[1:0];

    // Applies one alias operation to the enabled byte lanes only
    function automatic logic [31:0] alias_op(input logic [1:0]  op,
                                             input logic [31:0] cur,
                                             input logic [31:0] d,
                                             input logic [31:0] m);
        logic [31:0] dm;
        dm = d & m;
        case (op)
            OP_WRITE: alias_op = (cur & ~m) | dm;
            OP_SET:   alias_op = cur | dm;
            OP_CLR:   alias_op = cur & ~dm;
            default:  alias_op = cur ^ dm;
        endcase
    endfunction

    // State
    logic [LED_W-1:0]   ledr_q, ledr_d;
    logic [LED_W-1:0]   ledg_q, ledg_d;
    logic [7*N_HEX-1:0] hex_q, hex_d;
    logic [31:0]        mem_q [LCD_DEPTH];
    logic [31:0]        mem_d [LCD_DEPTH];
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               overflow_q, overflow_d;

`ifdef OUTPUT_BUFFER_BLINK_EN
    logic [LED_W-1:0]     blink_mask_q, blink_mask_d;
    logic [BLINK_DIV-1:0] blink_cnt_q, blink_cnt_d;
`endif

    // FIFO handshake terms
    logic full;
    logic valid;
    logic pop;
    logic push_req;
    logic push;

    assign full     = (count_q == CW'(LCD_DEPTH));
    assign valid    = (count_q != '0);
    assign pop      = valid && i_lcd_ready;
    assign push_req = wr && (word == W_LCD);
    assign push     = push_req && (!full || pop);

    // LED register updates through the write/set/clear/toggle aliases
    always_comb begin
        ledr_d = ledr_q;
        ledg_d = ledg_q;
        if (wr && (word[5:3] == 3'b000)) begin
            if (!word[2]) begin
                ledr_d = LED_W'(alias_op(word[1:0], 32'(ledr_q), wdata, lane_mask));
            end else begin
                ledg_d = LED_W'(alias_op(word[1:0], 32'(ledg_q), wdata, lane_mask));
            end
        end
    end

    // Seven-segment digit writes: byte lane k of word w feeds digit 4w+k
    always_comb begin
        hex_d = hex_q;
        if (wr && (word[5:2] == 4'b0010)) begin
            for (int w = 0; w < HEX_WORDS; w++) begin
                if (word[1:0] == 2'(w)) begin
                    for (int k = 0; k < 4; k++) begin
                        if (bus.i_wr_en[k]) begin
                            hex_d[7*(4*w+k) +: 7] = wdata[8*k +: 7];
                        end
                    end
                end
            end
        end
    end

    // LCD FIFO push/pop bookkeeping and sticky overflow flag
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (wr && (word == W_STATUS)) begin
            overflow_d = 1'b0;
        end else if (push_req && !push) begin
            overflow_d = 1'b1;
        end
    end

`ifdef OUTPUT_BUFFER_BLINK_EN
    // Blink mask writes and the free-running blink divider
    always_comb begin
        blink_mask_d = blink_mask_q;
        blink_cnt_d  = blink_cnt_q + BLINK_DIV'(1);
        if (wr && (word == W_BLINK)) begin
            blink_mask_d = LED_W'(alias_op(OP_WRITE, 32'(blink_mask_q), wdata, lane_mask));
        end
    end
`endif

    // All architectural state, cleared asynchronously
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ledr_q     <= '0;
            ledg_q     <= '0;
            hex_q      <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < LCD_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef OUTPUT_BUFFER_BLINK_EN
            blink_mask_q <= '0;
            blink_cnt_q  <= '0;
`endif
        end else begin
            ledr_q     <= ledr_d;
            ledg_q     <= ledg_d;
            hex_q      <= hex_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < LCD_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
`ifdef OUTPUT_BUFFER_BLINK_EN
            blink_mask_q <= blink_mask_d;
            blink_cnt_q  <= blink_cnt_d;
`endif
        end
    end

    // Output drive; the LCD head reads as zero whenever the FIFO is empty
`ifdef OUTPUT_BUFFER_BLINK_EN
    assign o_io_ledr = ledr_q & ~(blink_mask_q & {LED_W{blink_cnt_q[BLINK_DIV-1]}});
`else
    assign o_io_ledr = ledr_q;
`endif
    assign o_io_ledg   = ledg_q;
    assign o_io_hex    = hex_q;
    assign o_io_lcd    = valid ? mem_q[rd_ptr_q] : 32'h0;
    assign o_lcd_valid = valid;

    // Packs the addressed HEX word as four bytes with bit 7 of each lane zero
    logic [31:0] hex_rd;
    always_comb begin
        hex_rd = '0;
        for (int w = 0; w < HEX_WORDS; w++) begin
            if (word[1:0] == 2'(w)) begin
                for (int k = 0; k < 4; k++) begin
                    hex_rd[8*k +: 7] = hex_q[7*(4*w+k) +: 7];
                end
            end
        end
    end

    // Side-effect-free combinational readback of every mapped register
    logic [31:0] rd_data;
    always_comb begin
        rd_data = '0;
        if (hit) begin
            case (word)
                6'd0, 6'd1, 6'd2, 6'd3:   rd_data = 32'(ledr_q);
                6'd4, 6'd5, 6'd6, 6'd7:   rd_data = 32'(ledg_q);
                6'd8, 6'd9, 6'd10, 6'd11: rd_data = hex_rd;
                W_LCD:                    rd_data = o_io_lcd;
                W_STATUS:                 rd_data = {23'h0, overflow_q, full, 7'(count_q)};
`ifdef OUTPUT_BUFFER_BLINK_EN
                W_BLINK:                  rd_data = 32'(blink_mask_q);
`endif
                default:                  rd_data = '0;
            endcase
        end
    end

    assign bus.o_ld_data = rd_data;

endmodule

// File: tb/tb_output_buffer_mmio.sv
// tb/tb_output_buffer_mmio.sv - directed self-checking bench for output_buffer_mmio
module tb_output_buffer_mmio;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_lcd_ready;
    logic [31:0] o_io_ledr;
    logic [31:0] o_io_ledg;
    logic [55:0] o_io_hex;
    logic [31:0] o_io_lcd;
    logic        o_lcd_valid;

    int vectors;
    int miscompares;

    output_buffer_mmio_if bus ();

    output_buffer_mmio #(
        .BASE_ADDR (16'h7000),
        .LED_W     (32),
        .N_HEX     (8),
        .LCD_DEPTH (4),
        .BLINK_DIV (4)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .bus         (bus),
        .o_io_ledr   (o_io_ledr),
        .o_io_ledg   (o_io_ledg),
        .o_io_hex    (o_io_hex),
        .o_io_lcd    (o_io_lcd),
        .o_lcd_valid (o_lcd_valid),
        .i_lcd_ready (i_lcd_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] en);
        bus.i_addr    = addr;
        bus.i_wr_data = data;
        bus.i_wr_en   = en;
        @(posedge i_clk);
        #1;
        bus.i_wr_en   = 4'h0;
    endtask

    task automatic bus_read_check(input string tag, input logic [15:0] addr, input logic [31:0] exp);
        bus.i_addr  = addr;
        bus.i_wr_en = 4'h0;
        #1;
        check(tag, bus.o_ld_data, exp);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        i_rst_n       = 1'b0;
        i_lcd_ready   = 1'b0;
        bus.i_addr    = 16'h0;
        bus.i_wr_data = 32'h0;
        bus.i_wr_en   = 4'h0;

        // Reset state
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_ledr", o_io_ledr, 32'h0);
        check("rst_ledg", o_io_ledg, 32'h0);
        check("rst_hex_lo", o_io_hex[31:0], 32'h0);
        check("rst_hex_hi", 32'(o_io_hex[55:32]), 32'h0);
        check("rst_valid", 32'(o_lcd_valid), 32'h0);
        check("rst_lcd", o_io_lcd, 32'h0);
        i_rst_n = 1'b1;

        // LEDR aliases
        bus_write(16'h7000, 32'hA5A5_0F0F, 4'hF);
        check("ledr_write", o_io_ledr, 32'hA5A5_0F0F);
        bus_write(16'h7004, 32'h0000_00F0, 4'hF);
        check("ledr_set", o_io_ledr, 32'hA5A5_0FFF);
        bus_write(16'h7008, 32'h0000_000F, 4'hF);
        check("ledr_clr", o_io_ledr, 32'hA5A5_0FF0);
        bus_write(16'h700C, 32'hFFFF_0000, 4'hF);
        check("ledr_tog", o_io_ledr, 32'h5A5A_0FF0);
        bus_read_check("rd_ledr_set_alias", 16'h7004, 32'h5A5A_0FF0);
        bus_read_check("rd_ledr_low_bits_ignored", 16'h700F, 32'h5A5A_0FF0);

        // Out-of-window write is ignored
        bus_write(16'h7100, 32'h0, 4'hF);
        check("miss_window", o_io_ledr, 32'h5A5A_0FF0);

        // LEDG byte lanes
        bus_write(16'h7010, 32'h1122_3344, 4'b0011);
        check("ledg_lanes", o_io_ledg, 32'h0000_3344);
        bus_write(16'h7014, 32'hFFFF_FFFF, 4'b1000);
        check("ledg_set_lane3", o_io_ledg, 32'hFF00_3344);
        bus_read_check("rd_ledg_tog_alias", 16'h701C, 32'hFF00_3344);

        // HEX digits 4..7 via word 1, lanes 0 and 2
        bus_write(16'h7024, 32'h7F06_5B4F, 4'b0101);
        check("hex_d4", 32'(o_io_hex[34:28]), 32'h4F);
        check("hex_d5", 32'(o_io_hex[41:35]), 32'h0);
        check("hex_d6", 32'(o_io_hex[48:42]), 32'h06);
        check("hex_d7", 32'(o_io_hex[55:49]), 32'h0);
        check("hex_d0_3", 32'(o_io_hex[27:0]), 32'h0);
        bus_read_check("rd_hex_w1", 16'h7024, 32'h0006_004F);
        bus_read_check("rd_hex_w2_unmapped", 16'h7028, 32'h0);
        bus_read_check("rd_unmapped_40", 16'h7040, 32'h0);

        // LCD FIFO overflow and drain
        i_lcd_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            bus_write(16'h7030, 32'(i), 4'hF);
        end
        bus_read_check("status_ovf_full", 16'h7034, 32'h0000_0184);
        bus_read_check("rd_lcd_head", 16'h7030, 32'h1);
        check("lcd_valid_full", 32'(o_lcd_valid), 32'h1);
        i_lcd_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            check("drain_word", o_io_lcd, 32'(i));
            @(posedge i_clk);
            #1;
        end
        check("drain_empty_valid", 32'(o_lcd_valid), 32'h0);
        check("drain_empty_lcd", o_io_lcd, 32'h0);
        bus_write(16'h7034, 32'h0, 4'h1);
        bus_read_check("status_cleared", 16'h7034, 32'h0);

        // Push into a full FIFO while it pops in the same cycle
        i_lcd_ready = 1'b0;
        for (int i = 5; i <= 8; i++) begin
            bus_write(16'h7030, 32'(i), 4'hF);
        end
        bus_read_check("status_full", 16'h7034, 32'h0000_0084);
        i_lcd_ready = 1'b1;
        bus_write(16'h7030, 32'h9, 4'hF);
        check("full_pushpop_head", o_io_lcd, 32'h6);
        bus_read_check("full_pushpop_status", 16'h7034, 32'h0000_0084);
        for (int i = 7; i <= 9; i++) begin
            @(posedge i_clk);
            #1;
            check("pushpop_drain", o_io_lcd, 32'(i));
        end
        @(posedge i_clk);
        #1;
        check("pushpop_empty", 32'(o_lcd_valid), 32'h0);

        // Optional blink mask
`ifdef OUTPUT_BUFFER_BLINK_EN
        begin
            int seen_ff;
            int seen_f0;
            int seen_other;
            seen_ff    = 0;
            seen_f0    = 0;
            seen_other = 0;
            bus_write(16'h7000, 32'h0000_00FF, 4'hF);
            bus_write(16'h7038, 32'h0000_000F, 4'hF);
            bus_read_check("rd_blink_mask", 16'h7038, 32'h0000_000F);
            for (int c = 0; c < 32; c++) begin
                if (o_io_ledr == 32'hFF) seen_ff++;
                else if (o_io_ledr == 32'hF0) seen_f0++;
                else seen_other++;
                @(posedge i_clk);
                #1;
            end
            check("blink_seen_ff", 32'(seen_ff), 32'd16);
            check("blink_seen_f0", 32'(seen_f0), 32'd16);
            check("blink_seen_other", 32'(seen_other), 32'd0);
        end
`else
        bus_write(16'h7038, 32'h0000_000F, 4'hF);
        bus_read_check("rd_0x38_unmapped", 16'h7038, 32'h0);
        check("ledr_no_blink", o_io_ledr, 32'h5A5A_0FF0);
`endif

        // Asynchronous reset mid-drain
        i_lcd_ready = 1'b0;
        bus_write(16'h7010, 32'h0000_1234, 4'hF);
        check("ledg_pre_reset", o_io_ledg, 32'h0000_1234);
        bus_write(16'h7030, 32'hA, 4'hF);
        bus_write(16'h7030, 32'hB, 4'hF);
        i_lcd_ready = 1'b1;
        @(posedge i_clk);
        #1;
        check("mid_drain_head", o_io_lcd, 32'hB);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_ledr", o_io_ledr, 32'h0);
        check("arst_ledg", o_io_ledg, 32'h0);
        check("arst_hex_hi", 32'(o_io_hex[55:32]), 32'h0);
        check("arst_valid", 32'(o_lcd_valid), 32'h0);
        check("arst_lcd", o_io_lcd, 32'h0);
        bus_read_check("arst_status", 16'h7034, 32'h0);
        i_lcd_ready = 1'b0;
        i_rst_n     = 1'b1;
        @(posedge i_clk);
        #1;
        check("post_reset_valid", 32'(o_lcd_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
